// File: rtl/fir_stream_checker.sv
// fir_stream_checker
// Self-checking sink for FIR filter streams. Expected samples are queued in
// a small FIFO and compared in order against the filter output stream. The
// block counts matches and errors, flags protocol problems and stalls, and
// reports DONE/PASS once the run is over. It is fully synthesisable, so it
// can also sit next to the filter as on-chip BIST.
//
// Build option: define TOLERANCE_EN to accept |expected - actual| <= TOL.
// Without it the compare is exact bitwise equality and TOL has no effect.
//
// Stream handshakes:
//   Expected side: a sample is accepted on a rising edge where EXP_VIN=1 and
//   either EXP_READY=1 (FIFO not full) or a compare pops the FIFO in the
//   same cycle. EXP_VIN while full with no pop drops the sample and sets
//   OVERFLOW.
//   Filter side: DUT_DIN is taken on every rising edge where DUT_VIN=1; the
//   filter is never back-pressured. If the FIFO is empty at the start of
//   that cycle the sample is discarded and UNDERFLOW is set (no bypass).
//   Once DONE=1 both streams are ignored until RST.
//
// dbg_state_o exposes the control state: 0=IDLE 1=RUN 2=DRAIN 3=FIN.

module fir_stream_checker #(
    parameter int NB      = 9,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64,
    parameter int CW      = 16,
    parameter int TOL     = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EXP_VIN,
    input  logic [NB-1:0] EXP_DIN,
    output logic          EXP_READY,
    input  logic          DUT_VIN,
    input  logic [NB-1:0] DUT_DIN,
    input  logic          END_SIM,
    output logic          MISMATCH,
    output logic [NB-1:0] ERR_DATA,
    output logic [CW-1:0] MATCH_CNT,
    output logic [CW-1:0] ERR_CNT,
    output logic          OVERFLOW,
    output logic          UNDERFLOW,
    output logic          TIMEOUT_ERR,
    output logic          DONE,
    output logic          PASS,
    output logic [1:0]    dbg_state_o
);

    // Pointer index width; the extra MSB on each pointer separates full from empty.
    localparam int AW = $clog2(DEPTH);
    // Stall counter must be able to hold TIMEOUT itself.
    localparam int SW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    state_t state_q, state_d;

    // FIFO storage and pointers
    logic [NB-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          fifo_empty;
    logic          fifo_full;
    logic [NB-1:0] head;

    // Per-cycle events
    logic          active;
    logic          push;
    logic          pop;
    logic          cmp_ok;
    logic          stall_inc;
    logic          timeout_hit;

    // Result registers
    logic [SW-1:0] stall_q, stall_d;
    logic [CW-1:0] match_q, match_d;
    logic [CW-1:0] err_q, err_d;
    logic          mismatch_q, mismatch_d;
    logic [NB-1:0] err_data_q, err_data_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          timeout_q, timeout_d;

    // ------------------------------------------------------------------
    // FIFO status. Equal pointers mean empty; same index with differing
    // wrap bits means full. Wrap-around needs no special handling.
    // ------------------------------------------------------------------
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    // Both streams are frozen once the check has finished.
    assign active = (state_q != ST_FIN);

    // A pop needs a sample already in the FIFO at the start of the cycle.
    assign pop  = active && DUT_VIN && !fifo_empty;
    // A full FIFO still accepts a push when a pop frees a slot this cycle.
    assign push = active && EXP_VIN && (!fifo_full || pop);

    // Stall: the FIFO holds work but the filter produced nothing this cycle.
    assign stall_inc   = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                         !fifo_empty && !DUT_VIN;
    // Fires on the cycle whose increment brings the stall count to TIMEOUT.
    assign timeout_hit = stall_inc && (stall_q == SW'(TIMEOUT - 1));

    // ------------------------------------------------------------------
    // Sample compare
    // ------------------------------------------------------------------
`ifdef TOLERANCE_EN
    // One extra bit of headroom so the most negative minus the most
    // positive sample cannot wrap.
    logic signed [NB:0] diff;
    logic        [NB:0] diff_mag;

    assign diff     = $signed({head[NB-1], head}) - $signed({DUT_DIN[NB-1], DUT_DIN});
    assign diff_mag = diff[NB] ? $unsigned(-diff) : $unsigned(diff);
    assign cmp_ok   = (diff_mag <= (NB+1)'(TOL));
`else
    // TOL only matters for the tolerant compare.
    logic tol_unused;
    assign tol_unused = ^TOL;
    assign cmp_ok     = (head == DUT_DIN);
`endif

    // ------------------------------------------------------------------
    // Datapath next-state: pointers, counters, sticky flags, stall count.
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        match_d     = match_q;
        err_d       = err_q;
        mismatch_d  = 1'b0;
        err_data_d  = err_data_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        timeout_d   = timeout_q;
        stall_d     = stall_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (cmp_ok) begin
                if (match_q != {CW{1'b1}}) begin
                    match_d = match_q + 1'b1;
                end
            end else begin
                mismatch_d = 1'b1;
                err_data_d = DUT_DIN;
                if (err_q != {CW{1'b1}}) begin
                    err_d = err_q + 1'b1;
                end
            end
        end

        // Expected sample arrived with nowhere to go.
        if (active && EXP_VIN && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end

        // Filter sample arrived with nothing to compare against.
        if (active && DUT_VIN && fifo_empty) begin
            underflow_d = 1'b1;
        end

        // Any pop restarts the stall window; otherwise count up to TIMEOUT.
        if (pop) begin
            stall_d = '0;
        end else if (stall_inc && (stall_q != SW'(TIMEOUT))) begin
            stall_d = stall_q + 1'b1;
        end

        if (timeout_hit) begin
            timeout_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM next-state.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (END_SIM) begin
                    state_d = ST_FIN;
                end else if (EXP_VIN || DUT_VIN) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (timeout_hit) begin
                    state_d = ST_FIN;
                end else if (END_SIM) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Compares complete in the cycle of the pop, so an empty
                // FIFO means nothing is left in flight.
                if (timeout_hit || fifo_empty) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_FIN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and result registers with synchronous reset.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            match_q     <= '0;
            err_q       <= '0;
            mismatch_q  <= 1'b0;
            err_data_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            timeout_q   <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            match_q     <= match_d;
            err_q       <= err_d;
            mismatch_q  <= mismatch_d;
            err_data_q  <= err_data_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            timeout_q   <= timeout_d;
            stall_q     <= stall_d;
        end
    end

    // FIFO storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= EXP_DIN;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign EXP_READY   = !fifo_full;
    assign MISMATCH    = mismatch_q;
    assign ERR_DATA    = err_data_q;
    assign MATCH_CNT   = match_q;
    assign ERR_CNT     = err_q;
    assign OVERFLOW    = overflow_q;
    assign UNDERFLOW   = underflow_q;
    assign TIMEOUT_ERR = timeout_q;
    assign DONE        = (state_q == ST_FIN);
    assign PASS        = DONE && (err_q == '0) && !overflow_q && !underflow_q &&
                         !timeout_q && (match_q != '0);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fir_stream_checker.sv
// Directed bench for fir_stream_checker with a queue-based reference model
// checked every cycle, plus hand-computed expectations per scenario.
// Honours TOLERANCE_EN the same way as the design.

module tb_fir_stream_checker;

    localparam int NB      = 9;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 64;
    localparam int CW      = 16;
    localparam int TOL     = 1;
    localparam int MAXC    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          exp_vin = 1'b0;
    logic [NB-1:0] exp_din = '0;
    logic          dut_vin = 1'b0;
    logic [NB-1:0] dut_din = '0;
    logic          end_sim = 1'b0;

    logic          exp_ready;
    logic          mismatch;
    logic [NB-1:0] err_data;
    logic [CW-1:0] match_cnt;
    logic [CW-1:0] err_cnt;
    logic          overflow;
    logic          underflow;
    logic          timeout_err;
    logic          done;
    logic          pass;
    logic [1:0]    dbg_state;

    fir_stream_checker #(
        .NB(NB), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CW(CW), .TOL(TOL)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .EXP_VIN(exp_vin),
        .EXP_DIN(exp_din),
        .EXP_READY(exp_ready),
        .DUT_VIN(dut_vin),
        .DUT_DIN(dut_din),
        .END_SIM(end_sim),
        .MISMATCH(mismatch),
        .ERR_DATA(err_data),
        .MATCH_CNT(match_cnt),
        .ERR_CNT(err_cnt),
        .OVERFLOW(overflow),
        .UNDERFLOW(underflow),
        .TIMEOUT_ERR(timeout_err),
        .DONE(done),
        .PASS(pass),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {P_IDLE, P_RUN, P_DRAIN, P_FIN} phase_t;

    phase_t        m_phase = P_IDLE;
    logic [NB-1:0] exp_q[$];
    int            m_match = 0;
    int            m_err = 0;
    int            m_stall = 0;
    bit            m_mm = 1'b0;
    bit            m_ov = 1'b0;
    bit            m_un = 1'b0;
    bit            m_to = 1'b0;
    bit            model_on = 1'b0;
    logic [NB-1:0] m_err_data = '0;

    function automatic bit sample_ok(input logic [NB-1:0] e, input logic [NB-1:0] d);
`ifdef TOLERANCE_EN
        int de;
        int dd;
        int dist;
        de   = int'($signed(e));
        dd   = int'($signed(d));
        dist = (de > dd) ? (de - dd) : (dd - de);
        return (dist <= TOL);
`else
        return (e == d);
`endif
    endfunction

    // Model advances on every rising edge from the inputs the DUT sees.
    always @(posedge clk) begin
        int            occ;
        bit            popped;
        logic [NB-1:0] h;
        if (rst) begin
            exp_q.delete();
            m_phase    = P_IDLE;
            m_match    = 0;
            m_err      = 0;
            m_stall    = 0;
            m_mm       = 1'b0;
            m_ov       = 1'b0;
            m_un       = 1'b0;
            m_to       = 1'b0;
            m_err_data = '0;
            model_on   = 1'b1;
        end else if (m_phase != P_FIN) begin
            occ    = exp_q.size();
            popped = 1'b0;
            m_mm   = 1'b0;
            if (dut_vin && occ > 0) begin
                h       = exp_q.pop_front();
                popped  = 1'b1;
                m_stall = 0;
                if (sample_ok(h, dut_din)) begin
                    if (m_match < MAXC) m_match++;
                end else begin
                    if (m_err < MAXC) m_err++;
                    m_mm       = 1'b1;
                    m_err_data = dut_din;
                end
            end else if (dut_vin) begin
                m_un = 1'b1;
            end
            if (exp_vin) begin
                if (occ < DEPTH || popped) exp_q.push_back(exp_din);
                else m_ov = 1'b1;
            end
            if ((m_phase == P_RUN || m_phase == P_DRAIN) && occ > 0 && !dut_vin &&
                m_stall < TIMEOUT)
                m_stall++;
            case (m_phase)
                P_IDLE: begin
                    if (end_sim) m_phase = P_FIN;
                    else if (exp_vin || dut_vin) m_phase = P_RUN;
                end
                P_RUN: begin
                    if (m_stall == TIMEOUT) begin
                        m_to    = 1'b1;
                        m_phase = P_FIN;
                    end else if (end_sim) begin
                        m_phase = P_DRAIN;
                    end
                end
                P_DRAIN: begin
                    if (m_stall == TIMEOUT) begin
                        m_to    = 1'b1;
                        m_phase = P_FIN;
                    end else if (occ == 0) begin
                        m_phase = P_FIN;
                    end
                end
                default: ;
            endcase
        end else begin
            m_mm = 1'b0;
        end
    end

    // Every falling edge: all outputs against the model.
    always @(negedge clk) begin
        bit m_done;
        bit m_pass;
        if (model_on) begin
            m_done = (m_phase == P_FIN);
            m_pass = m_done && (m_err == 0) && !m_ov && !m_un && !m_to && (m_match > 0);
            check("model_exp_ready", exp_ready, (exp_q.size() != DEPTH));
            check("model_mismatch", mismatch, m_mm);
            check("model_err_data", err_data, m_err_data);
            check("model_match_cnt", match_cnt, m_match);
            check("model_err_cnt", err_cnt, m_err);
            check("model_overflow", overflow, m_ov);
            check("model_underflow", underflow, m_un);
            check("model_timeout_err", timeout_err, m_to);
            check("model_done", done, m_done);
            check("model_pass", pass, m_pass);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        exp_vin = 1'b0;
        dut_vin = 1'b0;
        end_sim = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_exp(input logic [NB-1:0] v);
        exp_vin = 1'b1;
        exp_din = v;
        tick();
        exp_vin = 1'b0;
    endtask

    task automatic send_dut(input logic [NB-1:0] v);
        dut_vin = 1'b1;
        dut_din = v;
        tick();
        dut_vin = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < max_cycles && !seen; n++) begin
            @(negedge clk);
            seen = done;
        end
        check(name, seen, 1'b1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int first_to;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_exp_ready", exp_ready, 1'b1);
        check("rst_match_cnt", match_cnt, 0);
        check("rst_err_data", err_data, 0);
        check("rst_done", done, 1'b0);
        check("rst_state_idle", dbg_state, 2'd0);

        // 1) Five matching samples, streamed back to back
        for (int i = 0; i < 5; i++) push_exp(NB'(9'h010 + i));
        dut_vin = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dut_din = NB'(9'h010 + i);
            tick();
        end
        dut_vin = 1'b0;
        end_sim = 1'b1;
        wait_done("t1_done", 10);
        check("t1_match_cnt", match_cnt, 5);
        check("t1_err_cnt", err_cnt, 0);
        check("t1_pass", pass, 1'b1);

        // 2) Off-by-one sample, then the extreme pair -256 vs 255
        do_reset();
        push_exp(9'h0A0);
        send_dut(9'h0A1);
        @(negedge clk);
`ifdef TOLERANCE_EN
        check("t2_mismatch", mismatch, 1'b0);
        check("t2_match_cnt", match_cnt, 1);
`else
        check("t2_mismatch", mismatch, 1'b1);
        check("t2_err_data", err_data, 9'h0A1);
        check("t2_err_cnt", err_cnt, 1);
`endif
        @(negedge clk);
        check("t2_mismatch_pulse_end", mismatch, 1'b0);
        push_exp(9'h100);
        send_dut(9'h0FF);
        @(negedge clk);
        check("t2_extreme_err_data", err_data, 9'h0FF);
`ifdef TOLERANCE_EN
        check("t2_extreme_err_cnt", err_cnt, 1);
`else
        check("t2_extreme_err_cnt", err_cnt, 2);
`endif
        end_sim = 1'b1;
        wait_done("t2_done", 10);
        check("t2_pass", pass, 1'b0);

        // 3) Fill to DEPTH, push+pop while full, then overflow
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_exp(NB'(7 + 3 * i));
        @(negedge clk);
        check("t3_full_ready", exp_ready, 1'b0);
        check("t3_full_overflow", overflow, 1'b0);
        exp_vin = 1'b1;
        exp_din = 9'h055;
        dut_vin = 1'b1;
        dut_din = 9'h007;
        tick();
        exp_vin = 1'b0;
        dut_vin = 1'b0;
        @(negedge clk);
        check("t3_pushpop_ready", exp_ready, 1'b0);
        check("t3_pushpop_overflow", overflow, 1'b0);
        check("t3_pushpop_match", match_cnt, 1);
        push_exp(9'h066);
        @(negedge clk);
        check("t3_overflow", overflow, 1'b1);
        check("t3_overflow_ready", exp_ready, 1'b0);

        // 4) DUT sample on an empty FIFO, same cycle as the first push
        do_reset();
        exp_vin = 1'b1;
        exp_din = 9'h033;
        dut_vin = 1'b1;
        dut_din = 9'h033;
        tick();
        exp_vin = 1'b0;
        dut_vin = 1'b0;
        @(negedge clk);
        check("t4_underflow", underflow, 1'b1);
        check("t4_match_unchanged", match_cnt, 0);
        check("t4_push_kept_ready", exp_ready, 1'b1);
        send_dut(9'h033);
        @(negedge clk);
        check("t4_kept_match", match_cnt, 1);
        end_sim = 1'b1;
        wait_done("t4_done", 10);
        check("t4_pass", pass, 1'b0);

        // 5) Stall: 3 queued, 1 consumed, then nothing more
        do_reset();
        push_exp(9'h001);
        push_exp(9'h002);
        push_exp(9'h003);
        send_dut(9'h001);
        end_sim  = 1'b1;
        first_to = -1;
        for (int n = 0; n < 80 && first_to < 0; n++) begin
            @(negedge clk);
            if (timeout_err) first_to = n;
        end
        check("t5_timeout_cycle", first_to, TIMEOUT);
        check("t5_done", done, 1'b1);
        check("t5_pass", pass, 1'b0);

        // 6) Reset in the middle of DRAIN, then a clean two-sample run
        do_reset();
        for (int i = 0; i < 4; i++) push_exp(NB'(9'h011 + i));
        end_sim = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("t6_in_drain", dbg_state, 2'd2);
        rst     = 1'b1;
        end_sim = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_ready", exp_ready, 1'b1);
        check("t6_rst_match", match_cnt, 0);
        check("t6_rst_timeout", timeout_err, 1'b0);
        check("t6_rst_done", done, 1'b0);
        check("t6_rst_state_idle", dbg_state, 2'd0);
        push_exp(9'h021);
        push_exp(9'h022);
        send_dut(9'h021);
        send_dut(9'h022);
        end_sim = 1'b1;
        wait_done("t6_done", 10);
        check("t6_match_cnt", match_cnt, 2);
        check("t6_pass", pass, 1'b1);

        end_sim = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
